// File: rtl/param_sub_accumulator_fb_if.sv
// Operand/control/result bundle for param_sub_accumulator_fb.
// master = requester driving operands, slave = accumulator.
interface param_sub_accumulator_fb_if #(
   parameter int IN_W  = 4,
   parameter int ACC_W = 8,
   parameter int CNT_W = 4
);
   logic [IN_W-1:0]  a;
   logic             mode;
   logic [CNT_W-1:0] iter;
   logic             start;
   logic             load;
   logic [ACC_W-1:0] load_val;
   logic             busy;
   logic             done;
   logic [ACC_W-1:0] result;
   logic             wrap;

   modport master (
      output a, mode, iter, start, load, load_val,
      input  busy, done, result, wrap
   );

   modport slave (
      input  a, mode, iter, start, load, load_val,
      output busy, done, result, wrap
   );
endinterface

// File: rtl/param_sub_accumulator_fb.sv
// Add/subtract accumulator that feeds its result back N times per start request.
// Define SUB_FB_SAT_EN to clamp at 0 / all-ones instead of wrapping modulo 2**ACC_W.
module param_sub_accumulator_fb #(
   parameter int               IN_W     = 4,
   parameter int               ACC_W    = 8,
   parameter int               CNT_W    = 4,
   parameter logic [ACC_W-1:0] INIT_VAL = '0
) (
   input logic                  clk,
   input logic                  rst,
   param_sub_accumulator_fb_if.slave bus
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q, state_d;
   logic [ACC_W-1:0] result_q, result_d;
   logic             wrap_q, wrap_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [IN_W-1:0]  a_q, a_d;
   logic             mode_q, mode_d;

   logic [ACC_W-1:0] a_ext;
   logic [ACC_W:0]   ext_sum;
   logic             overflow;
   logic [ACC_W-1:0] step;

   assign a_ext = ACC_W'(a_q);

   // Bit ACC_W of the extended sum is the carry (add) or the borrow (subtract).
   always_comb begin
      ext_sum  = mode_q ? ({1'b0, result_q} + {1'b0, a_ext})
                        : ({1'b0, result_q} - {1'b0, a_ext});
      overflow = ext_sum[ACC_W];
`ifdef SUB_FB_SAT_EN
      step = overflow ? (mode_q ? {ACC_W{1'b1}} : {ACC_W{1'b0}}) : ext_sum[ACC_W-1:0];
`else
      step = ext_sum[ACC_W-1:0];
`endif
   end

   always_comb begin
      // NOTE: every variable gets its hold value first, so no path can infer a latch.
      state_d  = state_q;
      result_d = result_q;
      wrap_d   = wrap_q;
      count_d  = count_q;
      a_d      = a_q;
      mode_d   = mode_q;
      case (state_q)
         IDLE: begin
            if (bus.load) begin
               result_d = bus.load_val;
            end else if (bus.start) begin
               a_d     = bus.a;
               mode_d  = bus.mode;
               count_d = bus.iter;
               wrap_d  = 1'b0;
               state_d = (bus.iter == '0) ? DONE : RUN;
            end
         end
         RUN: begin
            result_d = step;
            wrap_d   = wrap_q | overflow;
            count_d  = count_q - 1'b1;
            if (count_q == CNT_W'(1)) state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: non-blocking so every register samples pre-edge values; blocking here would race.
      if (rst) begin
         state_q  <= IDLE;
         result_q <= INIT_VAL;
         wrap_q   <= 1'b0;
         count_q  <= '0;
         a_q      <= '0;
         mode_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
         wrap_q   <= wrap_d;
         count_q  <= count_d;
         a_q      <= a_d;
         mode_q   <= mode_d;
      end
   end

   assign bus.busy   = (state_q != IDLE);
   assign bus.done   = (state_q == DONE);
   assign bus.result = result_q;
   assign bus.wrap   = wrap_q;

endmodule

// File: tb/tb_param_sub_accumulator_fb.sv
// Directed bench for param_sub_accumulator_fb with hand-computed expectations.
// Expected values follow SUB_FB_SAT_EN when the macro is defined.
module tb_param_sub_accumulator_fb;

   logic clk;
   logic rst;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   edges;
   int   seen;

   param_sub_accumulator_fb_if #(.IN_W(4), .ACC_W(8), .CNT_W(4)) bus ();

   param_sub_accumulator_fb #(
      .IN_W(4), .ACC_W(8), .CNT_W(4), .INIT_VAL(8'h00)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic do_load(input logic [7:0] v);
      bus.load     = 1'b1;
      bus.load_val = v;
      tick();
      bus.load     = 1'b0;
   endtask

   task automatic pulse_start(input logic [3:0] a, input logic mode, input logic [3:0] iter);
      bus.a     = a;
      bus.mode  = mode;
      bus.iter  = iter;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
   endtask

   // Counts edges after the start edge until done is seen; bounded.
   task automatic wait_done(inout int e);
      while (!bus.done && e < 40) begin
         tick();
         e++;
      end
   endtask

   initial begin
      rst = 1'b1;
      bus.a = '0; bus.mode = 1'b0; bus.iter = '0;
      bus.start = 1'b0; bus.load = 1'b0; bus.load_val = '0;
      tick();
      rst = 1'b0;
      check("rst_result", bus.result, 8'h00);
      check("rst_busy",   bus.busy,   0);
      check("rst_done",   bus.done,   0);
      check("rst_wrap",   bus.wrap,   0);

      // 100 - 4*5 = 80
      do_load(8'd100);
      check("load_100", bus.result, 8'd100);
      pulse_start(4'd5, 1'b0, 4'd4);
      check("run_busy", bus.busy, 1);
      edges = 0;
      wait_done(edges);
      check("sub_latency", edges, 4);
      check("sub_result",  bus.result, 8'd80);
      check("sub_wrap",    bus.wrap,   0);
      tick();
      check("done_one_cycle", bus.done, 0);
      check("idle_busy",      bus.busy, 0);
      tick();
      check("idle_hold", bus.result, 8'd80);

      // From 0: 0-5 borrows immediately
      do_load(8'h00);
      pulse_start(4'd5, 1'b0, 4'd3);
      for (int i = 0; i < 3; i++) begin
         logic [7:0] exp_r;
`ifdef SUB_FB_SAT_EN
         exp_r = 8'h00;
`else
         exp_r = 8'hFB - 8'(5 * i);
`endif
         tick();
         check("borrow_step", bus.result, exp_r);
      end
      check("borrow_done", bus.done, 1);
      check("borrow_wrap", bus.wrap, 1);
      tick();

      // load leaves wrap untouched; 250 + 15 carries
      do_load(8'd250);
      check("load_keeps_wrap", bus.wrap, 1);
      pulse_start(4'hF, 1'b1, 4'd1);
      edges = 0;
      wait_done(edges);
      check("carry_latency", edges, 1);
`ifdef SUB_FB_SAT_EN
      check("carry_result", bus.result, 8'hFF);
`else
      check("carry_result", bus.result, 8'h09);
`endif
      check("carry_wrap", bus.wrap, 1);
      tick();

      // iter = 0: done right after the start edge, wrap cleared
      pulse_start(4'd7, 1'b0, 4'd0);
      check("zero_done", bus.done, 1);
`ifdef SUB_FB_SAT_EN
      check("zero_result", bus.result, 8'hFF);
`else
      check("zero_result", bus.result, 8'h09);
`endif
      check("zero_wrap", bus.wrap, 0);
      tick();
      check("zero_back_idle", bus.busy, 0);

      // load wins over start in the same cycle
      bus.start = 1'b1; bus.iter = 4'd2; bus.a = 4'd1; bus.mode = 1'b1;
      do_load(8'h33);
      bus.start = 1'b0;
      check("load_prio_result", bus.result, 8'h33);
      check("load_prio_busy",   bus.busy,   0);
      tick();
      check("load_prio_busy2",  bus.busy,   0);

      // reset mid-run after 2 of 6 iterations
      do_load(8'h40);
      pulse_start(4'd3, 1'b1, 4'd6);
      tick();
      tick();
      check("mid_run_result", bus.result, 8'h46);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("midrst_result", bus.result, 8'h00);
      check("midrst_busy",   bus.busy,   0);
      check("midrst_wrap",   bus.wrap,   0);
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         if (bus.done) seen++;
         tick();
      end
      check("midrst_no_done", seen, 0);

      // same run with start/load/operand noise during RUN
      do_load(8'h40);
      pulse_start(4'd3, 1'b1, 4'd6);
      tick();
      tick();
      bus.start = 1'b1; bus.load = 1'b1; bus.load_val = 8'h77;
      bus.a = 4'd9; bus.mode = 1'b0; bus.iter = 4'd2;
      tick();
      bus.start = 1'b0; bus.load = 1'b0;
      edges = 3;
      wait_done(edges);
      check("noisy_latency", edges, 6);
      check("noisy_result",  bus.result, 8'h52);
      check("noisy_wrap",    bus.wrap,   0);
      tick();
      check("noisy_idle", bus.busy, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
